// File: rtl/instruction_encoder_pkg.sv
// Shared types and constants for the instruction encoder.
package instruction_encoder_pkg;

  // Instruction formats; codes 000-011 line up with the ImGenControl encoding.
  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b010,
    FMT_J = 3'b011,
    FMT_R = 3'b100,
    FMT_U = 3'b101
  } format_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // RV32I major opcodes.
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // True when value[31:lsb] are all equal, i.e. the value is a sign
  // extension of its low lsb+1 bits.
  function automatic logic sign_fits(input logic [31:0] value, input int unsigned lsb);
    logic signed [31:0] shifted;
    shifted = $signed(value) >>> lsb;
    return (shifted == 32'sh0000_0000) || (shifted == 32'shFFFF_FFFF);
  endfunction

endpackage

// File: rtl/instruction_encoder_imm_pack.sv
// Combinational RV32I word packing with immediate range check.
module imm_pack
  import instruction_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] Word,
  output logic        Legal
);

  // Scatter the immediate into its format-specific bit positions.
  always_comb begin
    Word  = 32'h0000_0000;
    Legal = 1'b0;
    case (fmt)
      FMT_I: begin
        Word  = {imm[11:0], rs1, funct3, rd, opcode};
        Legal = sign_fits(imm, 32'd11);
      end
      FMT_S: begin
        Word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        Legal = sign_fits(imm, 32'd11);
      end
      FMT_B: begin
        Word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        Legal = sign_fits(imm, 32'd12) && (imm[0] == 1'b0);
      end
      FMT_J: begin
        Word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        Legal = sign_fits(imm, 32'd20) && (imm[0] == 1'b0);
      end
      FMT_R: begin
        Word  = {funct7, rs2, rs1, funct3, rd, opcode};
        Legal = 1'b1;
      end
      FMT_U: begin
        Word  = {imm[31:12], rd, opcode};
        Legal = (imm[11:0] == 12'h000);
      end
      default: begin
        Word  = 32'h0000_0000;
        Legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Accepts field requests, packs them and streams words to instruction memory.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int COUNT_WIDTH = 16,
  parameter int ERR_WIDTH   = 8
) (
  input  logic                   Clock,
  input  logic                   ResetN,
  input  logic                   Start,
  input  logic [31:0]            StartAddress,
  input  logic [COUNT_WIDTH-1:0] Count,
  input  logic                   ReqValid,
  output logic                   ReqReady,
  input  logic [2:0]             ReqFormat,
  input  logic [6:0]             ReqOpcode,
  input  logic [4:0]             ReqRd,
  input  logic [4:0]             ReqRs1,
  input  logic [4:0]             ReqRs2,
  input  logic [2:0]             ReqFunct3,
  input  logic [6:0]             ReqFunct7,
  input  logic [31:0]            ReqImmediate,
  output logic                   MemWrite,
  output logic [31:0]            MemAddress,
  output logic [31:0]            MemData,
  input  logic                   MemReady,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Error,
  output logic [ERR_WIDTH-1:0]   ErrorCount
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_WIDTH-1:0]   ERR_ZERO = {ERR_WIDTH{1'b0}};
  localparam logic [ERR_WIDTH-1:0]   ERR_ONE  = {{(ERR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_WIDTH-1:0]   ERR_MAX  = {ERR_WIDTH{1'b1}};

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [31:0]            next_addr_q, next_addr_d;  // address the next packed word gets
  logic                   mem_write_q, mem_write_d;
  logic [31:0]            mem_addr_q, mem_addr_d;
  logic [31:0]            mem_data_q, mem_data_d;
  logic                   error_q, error_d;
  logic [ERR_WIDTH-1:0]   err_cnt_q, err_cnt_d;

  logic        req_ready_s;
  logic        accept_s;
  logic [31:0] word_s;
  logic        legal_s;

  imm_pack u_imm_pack (
    .fmt    (ReqFormat),
    .opcode (ReqOpcode),
    .rd     (ReqRd),
    .rs1    (ReqRs1),
    .rs2    (ReqRs2),
    .funct3 (ReqFunct3),
    .funct7 (ReqFunct7),
    .imm    (ReqImmediate),
    .Word   (word_s),
    .Legal  (legal_s)
  );

  // Next-state, count, address, output-register and error bookkeeping.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    next_addr_d = next_addr_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    error_d     = error_q;
    err_cnt_d   = err_cnt_q;
    // The output register frees up this cycle if its write completes.
    req_ready_s = (state_q == ST_RUN) && (remaining_q != CNT_ZERO) && (!mem_write_q || MemReady);
    accept_s    = ReqValid && req_ready_s;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          next_addr_d = StartAddress & 32'hFFFF_FFFC;
          remaining_d = Count;
          error_d     = 1'b0;
          err_cnt_d   = ERR_ZERO;
          state_d     = (Count == CNT_ZERO) ? ST_DONE : ST_RUN;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (mem_write_q && MemReady) begin
          mem_write_d = 1'b0;
        end else begin
          mem_write_d = mem_write_q;
        end
        if (accept_s) begin
          remaining_d = remaining_q - CNT_ONE;
          if (legal_s) begin
            mem_write_d = 1'b1;
            mem_addr_d  = next_addr_q;
            mem_data_d  = word_s;
            next_addr_d = next_addr_q + 32'd4;
          end else begin
            error_d = 1'b1;
            if (err_cnt_q != ERR_MAX) begin
              err_cnt_d = err_cnt_q + ERR_ONE;
            end else begin
              err_cnt_d = err_cnt_q;
            end
          end
        end else begin
          remaining_d = remaining_q;
        end
        if ((remaining_d == CNT_ZERO) && !mem_write_d) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q     <= ST_IDLE;
      remaining_q <= CNT_ZERO;
      next_addr_q <= 32'h0000_0000;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_data_q  <= 32'h0000_0000;
      error_q     <= 1'b0;
      err_cnt_q   <= ERR_ZERO;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      next_addr_q <= next_addr_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      error_q     <= error_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign ReqReady   = req_ready_s;
  assign MemWrite   = mem_write_q;
  assign MemAddress = mem_addr_q;
  assign MemData    = mem_data_q;
  assign Busy       = (state_q == ST_RUN);
  assign Done       = (state_q == ST_DONE);
  assign Error      = error_q;
  assign ErrorCount = err_cnt_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Randomized and directed bench for instruction_encoder with a transaction-level model.
module tb_instruction_encoder;

  localparam int CW   = 16;
  localparam int EW   = 4;
  localparam int EMAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          ResetN, Start, ReqValid, ReqReady, MemWrite, MemReady, Busy, Done, Error;
  logic [31:0]   StartAddress, ReqImmediate, MemAddress, MemData;
  logic [CW-1:0] Count;
  logic [2:0]    ReqFormat, ReqFunct3;
  logic [6:0]    ReqOpcode, ReqFunct7;
  logic [4:0]    ReqRd, ReqRs1, ReqRs2;
  logic [EW-1:0] ErrorCount;

  instruction_encoder #(.COUNT_WIDTH(CW), .ERR_WIDTH(EW)) dut (
    .Clock(clk), .ResetN(ResetN), .Start(Start), .StartAddress(StartAddress), .Count(Count),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqFormat(ReqFormat), .ReqOpcode(ReqOpcode),
    .ReqRd(ReqRd), .ReqRs1(ReqRs1), .ReqRs2(ReqRs2), .ReqFunct3(ReqFunct3), .ReqFunct7(ReqFunct7),
    .ReqImmediate(ReqImmediate), .MemWrite(MemWrite), .MemAddress(MemAddress), .MemData(MemData),
    .MemReady(MemReady), .Busy(Busy), .Done(Done), .Error(Error), .ErrorCount(ErrorCount)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;
  bit rand_mr = 1'b0;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } log_t;
  wr_t  exp_q[$];
  log_t wlog[$];

  // model state
  int          m_phase = 0;   // 0 idle, 1 run, 2 done
  int          m_rem = 0;
  logic [31:0] m_addr = 32'h0;
  bit          m_error = 1'b0;
  int          m_errcnt = 0;
  bit          m_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Legality from numeric ranges of the immediate.
  function automatic bit ref_legal(input logic [2:0] f, input logic [31:0] imm);
    int v;
    v = $signed(imm);
    case (f)
      3'd0, 3'd1: return (v >= -2048) && (v <= 2047);
      3'd2:       return (v >= -4096) && (v <= 4095) && (v % 2 == 0);
      3'd3:       return (v >= -1048576) && (v <= 1048575) && (v % 2 == 0);
      3'd4:       return 1'b1;
      3'd5:       return (imm % 32'd4096) == 32'd0;
      default:    return 1'b0;
    endcase
  endfunction

  // Word built by shifting masked fields into place.
  function automatic logic [31:0] ref_encode(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] w;
    w = 32'(op);
    case (f)
      3'd0: w = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | ((imm & 32'hFFF) << 20);
      3'd1: w = w | ((imm & 32'h1F) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20)
                  | (((imm >> 5) & 32'h7F) << 25);
      3'd2: w = w | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8) | (32'(f3) << 12)
                  | (32'(rs1) << 15) | (32'(rs2) << 20) | (((imm >> 5) & 32'h3F) << 25)
                  | (((imm >> 12) & 32'h1) << 31);
      3'd3: w = w | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 32'h1) << 20)
                  | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 32'h1) << 31);
      3'd4: w = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20)
                  | (32'(f7) << 25);
      3'd5: w = w | (32'(rd) << 7) | (imm & 32'hFFFF_F000);
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // ImmediateGenerator J decode (format 011) followed by the shift left by 1.
  function automatic logic [31:0] dec_j(input logic [31:0] w);
    logic [19:0] f;
    f = {w[31], w[19:12], w[20], w[30:21]};
    return {{11{f[19]}}, f, 1'b0};
  endfunction

  // Per-cycle compare against the model, then advance the model across the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      m_ready = (m_phase == 1) && (m_rem != 0) && ((exp_q.size() == 0) || MemReady);
      chk("Busy", 32'(Busy), 32'(m_phase == 1));
      chk("Done", 32'(Done), 32'(m_phase == 2));
      chk("Error", 32'(Error), 32'(m_error));
      chk("ErrorCount", 32'(ErrorCount), 32'(m_errcnt));
      chk("ReqReady", 32'(ReqReady), 32'(m_ready));
      chk("MemWrite", 32'(MemWrite), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("MemAddress", MemAddress, exp_q[0].addr);
        chk("MemData", MemData, exp_q[0].data);
      end
      if (MemWrite && MemReady) wlog.push_back('{MemAddress, MemData, cyc});
      if (!ResetN) begin
        m_phase = 0; m_rem = 0; m_error = 1'b0; m_errcnt = 0; exp_q.delete();
      end else if (m_phase != 1) begin
        if (Start) begin
          m_addr = StartAddress & 32'hFFFF_FFFC;
          m_rem = int'(Count);
          m_error = 1'b0;
          m_errcnt = 0;
          m_phase = (Count == '0) ? 2 : 1;
        end
      end else begin
        if ((exp_q.size() != 0) && MemReady) void'(exp_q.pop_front());
        if (ReqValid && m_ready) begin
          m_rem--;
          if (ref_legal(ReqFormat, ReqImmediate)) begin
            exp_q.push_back('{m_addr, ref_encode(ReqFormat, ReqOpcode, ReqRd, ReqRs1, ReqRs2,
                                                 ReqFunct3, ReqFunct7, ReqImmediate)});
            m_addr = m_addr + 32'd4;
          end else begin
            m_error = 1'b1;
            if (m_errcnt < EMAX) m_errcnt++;
          end
        end
        if ((m_rem == 0) && (exp_q.size() == 0)) m_phase = 2;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_run(input logic [31:0] a, input int n);
    StartAddress = a; Count = CW'(n); Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd, input logic [31:0] imm);
    bit ok;
    ReqFormat = f; ReqOpcode = op; ReqRd = rd; ReqImmediate = imm; ReqValid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (ReqReady) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: got ReqReady=0 for 200 cycles want 1");
    end
    ReqValid = 1'b0;
  endtask

  task automatic wait_done(output int dcyc);
    bit seen;
    seen = 1'b0; dcyc = -1;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (Done) begin seen = 1'b1; dcyc = cyc; end
    end
    @(posedge clk); #1;
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got Done=0 for 500 cycles want 1");
    end
  endtask

  task automatic chk_zero(input string tag);
    @(negedge clk);
    chk({tag, "_MemWrite"}, 32'(MemWrite), 32'd0);
    chk({tag, "_MemAddress"}, MemAddress, 32'd0);
    chk({tag, "_MemData"}, MemData, 32'd0);
    chk({tag, "_Busy"}, 32'(Busy), 32'd0);
    chk({tag, "_Done"}, 32'(Done), 32'd0);
    chk({tag, "_Error"}, 32'(Error), 32'd0);
    chk({tag, "_ErrorCount"}, 32'(ErrorCount), 32'd0);
    chk({tag, "_ReqReady"}, 32'(ReqReady), 32'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 4095)) - 32'd2048;
      1: return $urandom;
      2: return $urandom & 32'hFFFF_F000;
      default: return (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFF_FFFE;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d, n;
    logic [31:0] snap;
    ResetN = 1'b0; Start = 1'b0; StartAddress = 32'h0; Count = '0; ReqValid = 1'b0;
    ReqFormat = 3'd0; ReqOpcode = 7'h0; ReqRd = 5'd0; ReqRs1 = 5'd0; ReqRs2 = 5'd0;
    ReqFunct3 = 3'd0; ReqFunct7 = 7'd0; ReqImmediate = 32'h0; MemReady = 1'b1;
    tick();
    mon_en = 1'b1;
    chk_zero("reset");
    ResetN = 1'b1;
    tick();

    // three back-to-back writes with MemReady high
    wlog.delete();
    start_run(32'h100, 3);
    send(3'd0, 7'h13, 5'd0, 32'hFFFF_FFFF);
    send(3'd1, 7'h23, 5'd0, 32'h0000_07FF);
    send(3'd2, 7'h63, 5'd0, 32'hFFFF_F000);
    wait_done(d);
    chk("t1_nwrites", 32'(wlog.size()), 32'd3);
    if (wlog.size() == 3) begin
      chk("t1_addr0", wlog[0].addr, 32'h100);
      chk("t1_addr1", wlog[1].addr, 32'h104);
      chk("t1_addr2", wlog[2].addr, 32'h108);
      chk("t1_word0", wlog[0].data, 32'hFFF0_0013);
      chk("t1_consec", 32'(wlog[2].cyc - wlog[0].cyc), 32'd2);
      chk("t1_done_lat", 32'(d - wlog[2].cyc), 32'd1);
    end

    // J packing and round trip through the decoder
    wlog.delete();
    start_run(32'h200, 1);
    send(3'd3, 7'h6F, 5'd1, 32'h000F_FFFE);
    wait_done(d);
    chk("t2_nwrites", 32'(wlog.size()), 32'd1);
    if (wlog.size() == 1) begin
      chk("t2_word", wlog[0].data, 32'h7FFF_F0EF);
      chk("t2_decode", dec_j(wlog[0].data), 32'h000F_FFFE);
    end

    // all-rejected run
    wlog.delete();
    start_run(32'h300, 3);
    send(3'd2, 7'h63, 5'd0, 32'd3);
    send(3'd0, 7'h13, 5'd0, 32'd2048);
    send(3'd6, 7'h13, 5'd0, 32'd0);
    wait_done(d);
    chk("t3_nwrites", 32'(wlog.size()), 32'd0);
    chk("t3_errcnt", 32'(ErrorCount), 32'd3);
    chk("t3_error", 32'(Error), 32'd1);
    // rejects do not advance the address: the legal word lands at the start address
    wlog.delete();
    start_run(32'h340, 4);
    send(3'd7, 7'h13, 5'd0, 32'd0);
    send(3'd5, 7'h37, 5'd0, 32'd1);
    send(3'd3, 7'h6F, 5'd0, 32'd1);
    send(3'd4, 7'h33, 5'd2, 32'd0);
    wait_done(d);
    chk("t3b_nwrites", 32'(wlog.size()), 32'd1);
    if (wlog.size() == 1) chk("t3b_addr", wlog[0].addr, 32'h340);

    // back-pressure: MemReady low for 4 cycles with a second request waiting
    wlog.delete();
    start_run(32'h400, 2);
    send(3'd0, 7'h13, 5'd0, 32'd5);
    MemReady = 1'b0;
    ReqFormat = 3'd4; ReqOpcode = 7'h33; ReqRd = 5'd3; ReqValid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_ready_low", 32'(ReqReady), 32'd0);
      chk("t4_addr_hold", MemAddress, 32'h400);
      chk("t4_data_hold", MemData, 32'h0050_0013);
      @(posedge clk); #1;
    end
    MemReady = 1'b1;
    send(3'd4, 7'h33, 5'd3, 32'd0);
    wait_done(d);
    chk("t4_nwrites", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("t4_addr1", wlog[1].addr, 32'h404);
      chk("t4_gap", 32'(wlog[1].cyc - wlog[0].cyc), 32'd1);
    end

    // Count of zero goes straight to DONE
    wlog.delete();
    start_run(32'h700, 0);
    @(negedge clk);
    chk("t5_done", 32'(Done), 32'd1);
    chk("t5_busy", 32'(Busy), 32'd0);
    @(posedge clk); #1;
    tick();
    chk("t5_nwrites", 32'(wlog.size()), 32'd0);

    // Start during RUN is ignored
    wlog.delete();
    start_run(32'h500, 2);
    start_run(32'h900, 5);
    send(3'd0, 7'h13, 5'd4, 32'd1);
    send(3'd0, 7'h13, 5'd4, 32'd2);
    wait_done(d);
    chk("t6_nwrites", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("t6_addr0", wlog[0].addr, 32'h500);
      chk("t6_addr1", wlog[1].addr, 32'h504);
    end

    // address wraps modulo 2^32
    wlog.delete();
    start_run(32'hFFFF_FFFC, 2);
    send(3'd5, 7'h37, 5'd7, 32'h1234_5000);
    send(3'd5, 7'h37, 5'd8, 32'h0000_1000);
    wait_done(d);
    chk("t8_nwrites", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("t8_addr0", wlog[0].addr, 32'hFFFF_FFFC);
      chk("t8_addr1", wlog[1].addr, 32'h0000_0000);
    end

    // error counter saturates
    start_run(32'h800, 20);
    for (int k = 0; k < 20; k++) send(3'd6, 7'h13, 5'd0, 32'd0);
    wait_done(d);
    chk("t9_errsat", 32'(ErrorCount), 32'(EMAX));

    // reset mid-run drops the pending write
    start_run(32'h600, 3);
    send(3'd7, 7'h13, 5'd0, 32'd0);
    MemReady = 1'b0;
    send(3'd0, 7'h13, 5'd1, 32'd9);
    ResetN = 1'b0;
    tick();
    chk_zero("t7");
    ResetN = 1'b1;
    MemReady = 1'b1;
    tick();

    // randomized runs with random back-pressure
    rand_mr = 1'b1;
    fork
      begin
        while (rand_mr) begin
          @(posedge clk); #1;
          MemReady = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 24);
      start_run($urandom, n);
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        ReqRs1 = 5'($urandom); ReqRs2 = 5'($urandom);
        ReqFunct3 = 3'($urandom); ReqFunct7 = 7'($urandom);
        send(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), rand_imm());
      end
      wait_done(d);
    end
    rand_mr = 1'b0;
    tick();
    MemReady = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
